// File: rtl/writeback_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// writeback_forward_unit_pkg
// Shared types and helpers for the writeback/forwarding slice:
//   DATA, REGISTERWIDTH   datapath and register-index widths
//   fwd_sel_e             operand source select (regfile / EX/MEM / MEM/WB)
//   hazard_state_e        load-use hazard FSM states
//   stage_t               pipeline stage record {valid,rd,regwrite,memread,data}
//   stage_hit/fwd_select  forwarding priority helpers
//   sat_inc               saturating counter step (used when FWD_STATS_EN is defined)
// -----------------------------------------------------------------------------
package writeback_forward_unit_pkg;

  localparam int DATA          = 32;
  localparam int REGISTERWIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazard_state_e;

  typedef struct packed {
    logic                     valid;
    logic [REGISTERWIDTH-1:0] rd;
    logic                     regwrite;
    logic                     memread;
    logic [DATA-1:0]          data;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{
    valid:    1'b0,
    rd:       {REGISTERWIDTH{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0,
    data:     {DATA{1'b0}}
  };

  // A stage can supply operand src when it holds a real register write to src.
  // allow_load=0 excludes loads: their data is not known until MEM/WB.
  function automatic logic stage_hit(input stage_t s,
                                     input logic [REGISTERWIDTH-1:0] src,
                                     input logic allow_load);
    return s.valid & s.regwrite & (allow_load | ~s.memread) & (s.rd == src);
  endfunction

  // Youngest producer wins: EX/MEM is checked before MEM/WB. x0 always reads regfile.
  function automatic fwd_sel_e fwd_select(input logic [REGISTERWIDTH-1:0] src,
                                          input stage_t exmem,
                                          input stage_t memwb);
    fwd_sel_e sel;
    if (src == {REGISTERWIDTH{1'b0}}) begin
      sel = FWD_RF;
    end else if (stage_hit(exmem, src, 1'b0)) begin
      sel = FWD_EXMEM;
    end else if (stage_hit(memwb, src, 1'b1)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    logic [31:0] r;
    if (en && (v != 32'hFFFF_FFFF)) begin
      r = v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/writeback_forward_unit_if.sv
// -----------------------------------------------------------------------------
// writeback_forward_unit_if
// Bundles the EX/ID/MEM inputs and the forwarding, hazard and register-file
// write outputs of writeback_forward_unit.
//   master : pipeline side, drives ex_*, id_*, mem_loaddata; sees the results
//   slave  : writeback_forward_unit side
// With FWD_STATS_EN defined, stall_count and fwd_count are added.
// -----------------------------------------------------------------------------
interface writeback_forward_unit_if #(
  parameter int DATA          = writeback_forward_unit_pkg::DATA,
  parameter int REGISTERWIDTH = writeback_forward_unit_pkg::REGISTERWIDTH
);
  import writeback_forward_unit_pkg::*;

  logic                     ex_valid;
  logic [REGISTERWIDTH-1:0] ex_rd;
  logic                     ex_regwrite;
  logic                     ex_memread;
  logic [DATA-1:0]          ex_result;
  logic [REGISTERWIDTH-1:0] ex_rs1;
  logic [REGISTERWIDTH-1:0] ex_rs2;
  logic [DATA-1:0]          ex_rf_data1;
  logic [DATA-1:0]          ex_rf_data2;
  logic [REGISTERWIDTH-1:0] id_rs1;
  logic [REGISTERWIDTH-1:0] id_rs2;
  logic [DATA-1:0]          mem_loaddata;

  logic [DATA-1:0]          ex_opA;
  logic [DATA-1:0]          ex_opB;
  logic [1:0]               fwd_selA;
  logic [1:0]               fwd_selB;
  logic                     stall_id;
  logic                     ex_bubble;
  logic                     wb_writeEnable;
  logic [REGISTERWIDTH-1:0] wb_rd;
  logic [DATA-1:0]          wb_writeData;
`ifdef FWD_STATS_EN
  logic [31:0]              stall_count;
  logic [31:0]              fwd_count;
`endif

  modport master (
    output ex_valid, ex_rd, ex_regwrite, ex_memread, ex_result,
    output ex_rs1, ex_rs2, ex_rf_data1, ex_rf_data2,
    output id_rs1, id_rs2, mem_loaddata,
    input  ex_opA, ex_opB, fwd_selA, fwd_selB, stall_id, ex_bubble,
    input  wb_writeEnable, wb_rd, wb_writeData
`ifdef FWD_STATS_EN
    , input stall_count, fwd_count
`endif
  );

  modport slave (
    input  ex_valid, ex_rd, ex_regwrite, ex_memread, ex_result,
    input  ex_rs1, ex_rs2, ex_rf_data1, ex_rf_data2,
    input  id_rs1, id_rs2, mem_loaddata,
    output ex_opA, ex_opB, fwd_selA, fwd_selB, stall_id, ex_bubble,
    output wb_writeEnable, wb_rd, wb_writeData
`ifdef FWD_STATS_EN
    , output stall_count, fwd_count
`endif
  );

endinterface

// File: rtl/writeback_forward_unit_fwd_stage_reg.sv
// -----------------------------------------------------------------------------
// fwd_stage_reg
// One pipeline stage record register, loaded on every clock edge.
//   clk, reset : clock and asynchronous active-high reset (clears to empty)
//   d          : next stage record
//   q          : current stage record
// -----------------------------------------------------------------------------
module fwd_stage_reg
  import writeback_forward_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  stage_t d,
  output stage_t q
);

  // Stage record: empty on reset, otherwise follows d every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= STAGE_EMPTY;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/writeback_forward_unit.sv
// -----------------------------------------------------------------------------
// writeback_forward_unit
// Tracks EX/MEM and MEM/WB destinations, drives the register-file write port,
// forwards EX operands from EX/MEM or MEM/WB, and stalls one cycle on load-use.
//   clk    : clock, all state on posedge
//   reset  : asynchronous active-high reset
//   bus    : writeback_forward_unit_if.slave
//            in : ex_valid/rd/regwrite/memread/result, ex_rs1/2, ex_rf_data1/2,
//                 id_rs1/2, mem_loaddata
//            out: ex_opA/B, fwd_selA/B (combinational), stall_id, ex_bubble,
//                 wb_writeEnable, wb_rd, wb_writeData
// Optional: FWD_STATS_EN adds saturating stall_count / fwd_count.
// -----------------------------------------------------------------------------
module writeback_forward_unit #(
  parameter int DATA          = writeback_forward_unit_pkg::DATA,
  parameter int REGISTERWIDTH = writeback_forward_unit_pkg::REGISTERWIDTH
) (
  input logic                     clk,
  input logic                     reset,
  writeback_forward_unit_if.slave bus
);
  import writeback_forward_unit_pkg::*;

  localparam logic [REGISTERWIDTH-1:0] REG_ZERO = {REGISTERWIDTH{1'b0}};

  stage_t        exmem_d_s;
  stage_t        exmem_q_r;
  stage_t        memwb_d_s;
  stage_t        memwb_q_r;
  fwd_sel_e      sel_a_s;
  fwd_sel_e      sel_b_s;
  logic [DATA-1:0] op_a_s;
  logic [DATA-1:0] op_b_s;
  hazard_state_e state_r;
  hazard_state_e state_next_s;
  logic          load_use_s;
  logic          stall_s;

  // Capture the EX instruction as an EX/MEM record.
  always_comb begin
    exmem_d_s          = STAGE_EMPTY;
    exmem_d_s.valid    = bus.ex_valid;
    exmem_d_s.rd       = bus.ex_rd;
    exmem_d_s.regwrite = bus.ex_regwrite;
    exmem_d_s.memread  = bus.ex_memread;
    exmem_d_s.data     = bus.ex_result;
  end

  // Loads pick up their memory data on the way into MEM/WB.
  always_comb begin
    memwb_d_s = exmem_q_r;
    if (exmem_q_r.memread) begin
      memwb_d_s.data = bus.mem_loaddata;
    end else begin
      memwb_d_s.data = exmem_q_r.data;
    end
  end

  fwd_stage_reg u_exmem (
    .clk   (clk),
    .reset (reset),
    .d     (exmem_d_s),
    .q     (exmem_q_r)
  );

  fwd_stage_reg u_memwb (
    .clk   (clk),
    .reset (reset),
    .d     (memwb_d_s),
    .q     (memwb_q_r)
  );

  // Forwarding source per operand.
  always_comb begin
    sel_a_s = fwd_select(bus.ex_rs1, exmem_q_r, memwb_q_r);
    sel_b_s = fwd_select(bus.ex_rs2, exmem_q_r, memwb_q_r);
  end

  // Operand A mux.
  always_comb begin
    op_a_s = bus.ex_rf_data1;
    case (sel_a_s)
      FWD_RF:    op_a_s = bus.ex_rf_data1;
      FWD_EXMEM: op_a_s = exmem_q_r.data;
      FWD_MEMWB: op_a_s = memwb_q_r.data;
      default:   op_a_s = bus.ex_rf_data1;
    endcase
  end

  // Operand B mux.
  always_comb begin
    op_b_s = bus.ex_rf_data2;
    case (sel_b_s)
      FWD_RF:    op_b_s = bus.ex_rf_data2;
      FWD_EXMEM: op_b_s = exmem_q_r.data;
      FWD_MEMWB: op_b_s = memwb_q_r.data;
      default:   op_b_s = bus.ex_rf_data2;
    endcase
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    if (bus.ex_valid && bus.ex_memread && (bus.ex_rd != REG_ZERO) &&
        ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Hazard FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Hazard FSM next state: one STALL cycle per detected load-use.
  always_comb begin
    state_next_s = RUN;
    case (state_r)
      RUN: begin
        if (load_use_s) begin
          state_next_s = STALL;
        end else begin
          state_next_s = RUN;
        end
      end
      STALL:   state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // Hazard FSM outputs. Gating with reset drops the stall at once when reset
  // arrives, even if the inputs still describe a load-use pair.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      RUN: begin
        if (load_use_s && !reset) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      STALL:   stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign bus.ex_opA         = op_a_s;
  assign bus.ex_opB         = op_b_s;
  assign bus.fwd_selA       = sel_a_s;
  assign bus.fwd_selB       = sel_b_s;
  assign bus.stall_id       = stall_s;
  assign bus.ex_bubble      = stall_s;
  // x0 is hardwired zero, so a write to it is dropped here.
  assign bus.wb_writeEnable = memwb_q_r.valid & memwb_q_r.regwrite &
                              (memwb_q_r.rd != REG_ZERO);
  assign bus.wb_rd          = memwb_q_r.rd;
  assign bus.wb_writeData   = memwb_q_r.data;

`ifdef FWD_STATS_EN
  logic [31:0] stall_count_r;
  logic [31:0] fwd_count_r;
  logic        fwd_any_s;

  assign fwd_any_s = bus.ex_valid & ((sel_a_s != FWD_RF) | (sel_b_s != FWD_RF));

  // Saturating stall-cycle and forwarding-cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_r <= 32'd0;
      fwd_count_r   <= 32'd0;
    end else begin
      stall_count_r <= sat_inc(stall_count_r, stall_s);
      fwd_count_r   <= sat_inc(fwd_count_r, fwd_any_s);
    end
  end

  assign bus.stall_count = stall_count_r;
  assign bus.fwd_count   = fwd_count_r;
`endif

endmodule
